decode_cycle: RTL and testbench

Decode stage of the 5-stage MIPS pipeline. Consumes the Fetch stage's registered outputs (instrD, pcD, pcplus4D), decodes the instruction into control signals, reads the 32x32 register file, which is written by Writeback, and extends the immediate. The result is registered into the D->E pipeline register for Execute. Decode also squashes the two wrong-path instructions that follow a taken branch reported by Execute.

---
 rtl/decode_cycle.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - MIPS decode stage: control decode, 32x32 register file, immediate extension, D->E register, branch squash
// Optional feature: define WB_BYPASS_EN to make the register file read ports write-through.

module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrD,
  input  logic [31:0] pcD,
  input  logic [31:0] pcplus4D,
  input  logic        isbranchtakenE,
  input  logic        regwriteW,
  input  logic [4:0]  rdW,
  input  logic [31:0] resultW,
  output logic [31:0] rd1E,
  output logic [31:0] rd2E,
  output logic [31:0] immE,
  output logic [4:0]  rsE,
  output logic [4:0]  rtE,
  output logic [4:0]  rdE,
  output logic [4:0]  shamtE,
  output logic [31:0] pcE,
  output logic [31:0] pcplus4E,
  output logic [3:0]  aluopE,
  output logic        regwriteE,
  output logic        memreadE,
  output logic        memwriteE,
  output logic        memtoregE,
  output logic        alusrcE,
  output logic        branchE,
  output logic        bneE,
  output logic        jumpE,
  output logic        illegalE
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IMM_SIGN = 2'd0,
    IMM_ZERO = 2'd1,
    IMM_LUI  = 2'd2,
    IMM_JUMP = 2'd3
  } imm_sel_t;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign op    = instrD[31:26];
  assign rs    = instrD[25:21];
  assign rt    = instrD[20:16];
  assign rd    = instrD[15:11];
  assign shamt = instrD[10:6];
  assign funct = instrD[5:0];
  assign imm16 = instrD[15:0];

  logic [31:0] regs [32];
  logic        kill_q;
  logic        flushD;

  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [4:0]  dst;
  logic [3:0]  aluop;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic        memtoreg;
  logic        alusrc;
  logic        branch;
  logic        bne;
  logic        jump;
  logic        illegal;
  logic        r_ok;
  imm_sel_t    imm_sel;

  // Register file write port; $0 is never written so it always reads back 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (regwriteW && (rdW != 5'd0)) begin
      regs[rdW] <= resultW;
    end
  end

  // Combinational read ports, optionally forwarding the same-cycle Writeback value
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != 5'd0) begin
`ifdef WB_BYPASS_EN
      if (regwriteW && (rdW == rs)) rd1 = resultW;
      else                          rd1 = regs[rs];
`else
      rd1 = regs[rs];
`endif
    end
    if (rt != 5'd0) begin
`ifdef WB_BYPASS_EN
      if (regwriteW && (rdW == rt)) rd2 = resultW;
      else                          rd2 = regs[rt];
`else
      rd2 = regs[rt];
`endif
    end
  end

  // Control decode; every I-type that produces a result writes rt, so those set regwrite too
  always_comb begin
    aluop    = ALU_ADD;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    alusrc   = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    jump     = 1'b0;
    illegal  = 1'b0;
    r_ok     = 1'b1;
    imm_sel  = IMM_SIGN;
    if (instrD != 32'h0) begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            FN_ADD:  aluop = ALU_ADD;
            FN_SUB:  aluop = ALU_SUB;
            FN_AND:  aluop = ALU_AND;
            FN_OR:   aluop = ALU_OR;
            FN_SLT:  aluop = ALU_SLT;
            FN_SLL:  aluop = ALU_SLL;
            FN_SRL:  aluop = ALU_SRL;
            default: r_ok  = 1'b0;
          endcase
          if (r_ok) begin
            regwrite = 1'b1;
          end else begin
            aluop   = ALU_ADD;
            illegal = 1'b1;
          end
        end
        OP_ADDI: begin
          aluop    = ALU_ADD;
          alusrc   = 1'b1;
          regwrite = 1'b1;
        end
        OP_ANDI: begin
          aluop    = ALU_AND;
          alusrc   = 1'b1;
          regwrite = 1'b1;
          imm_sel  = IMM_ZERO;
        end
        OP_ORI: begin
          aluop    = ALU_OR;
          alusrc   = 1'b1;
          regwrite = 1'b1;
          imm_sel  = IMM_ZERO;
        end
        OP_LUI: begin
          aluop    = ALU_LUI;
          alusrc   = 1'b1;
          regwrite = 1'b1;
          imm_sel  = IMM_LUI;
        end
        OP_LW: begin
          aluop    = ALU_ADD;
          alusrc   = 1'b1;
          memread  = 1'b1;
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        OP_SW: begin
          aluop    = ALU_ADD;
          alusrc   = 1'b1;
          memwrite = 1'b1;
        end
        OP_BEQ: begin
          aluop  = ALU_SUB;
          branch = 1'b1;
        end
        OP_BNE: begin
          aluop  = ALU_SUB;
          branch = 1'b1;
          bne    = 1'b1;
        end
        OP_J: begin
          jump    = 1'b1;
          imm_sel = IMM_JUMP;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  // Immediate extension and register destination select
  always_comb begin
    imm = {{16{imm16[15]}}, imm16};
    case (imm_sel)
      IMM_SIGN: imm = {{16{imm16[15]}}, imm16};
      IMM_ZERO: imm = {16'h0, imm16};
      IMM_LUI:  imm = {imm16, 16'h0};
      IMM_JUMP: imm = {pcplus4D[31:28], instrD[25:0], 2'b00};
      default:  imm = {{16{imm16[15]}}, imm16};
    endcase
    dst = (op == OP_RTYPE) ? rd : rt;
  end

  // Second squash cycle covers the instruction Fetch latched on the resolving edge
  always_ff @(posedge clk) begin
    if (rst) kill_q <= 1'b0;
    else     kill_q <= isbranchtakenE;
  end

  assign flushD = isbranchtakenE | kill_q;

  // D->E pipeline register; reset and squash both load an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      rd1E      <= '0;
      rd2E      <= '0;
      immE      <= '0;
      rsE       <= '0;
      rtE       <= '0;
      rdE       <= '0;
      shamtE    <= '0;
      pcE       <= '0;
      pcplus4E  <= '0;
      aluopE    <= '0;
      regwriteE <= 1'b0;
      memreadE  <= 1'b0;
      memwriteE <= 1'b0;
      memtoregE <= 1'b0;
      alusrcE   <= 1'b0;
      branchE   <= 1'b0;
      bneE      <= 1'b0;
      jumpE     <= 1'b0;
      illegalE  <= 1'b0;
    end else begin
      rd1E      <= rd1;
      rd2E      <= rd2;
      immE      <= imm;
      rsE       <= rs;
      rtE       <= rt;
      rdE       <= dst;
      shamtE    <= shamt;
      pcE       <= pcD;
      pcplus4E  <= pcplus4D;
      aluopE    <= aluop;
      regwriteE <= regwrite;
      memreadE  <= memread;
      memwriteE <= memwrite;
      memtoregE <= memtoreg;
      alusrcE   <= alusrc;
      branchE   <= branch;
      bneE      <= bne;
      jumpE     <= jump;
      illegalE  <= illegal;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - scoreboard bench for decode_cycle with a table-driven reference model

module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrD, pcD, pcplus4D;
  logic        isbranchtakenE, regwriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic [31:0] rd1E, rd2E, immE, pcE, pcplus4E;
  logic [4:0]  rsE, rtE, rdE, shamtE;
  logic [3:0]  aluopE;
  logic        regwriteE, memreadE, memwriteE, memtoregE, alusrcE, branchE, bneE, jumpE, illegalE;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
    .isbranchtakenE(isbranchtakenE), .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW),
    .rd1E(rd1E), .rd2E(rd2E), .immE(immE), .rsE(rsE), .rtE(rtE), .rdE(rdE), .shamtE(shamtE),
    .pcE(pcE), .pcplus4E(pcplus4E), .aluopE(aluopE), .regwriteE(regwriteE), .memreadE(memreadE),
    .memwriteE(memwriteE), .memtoregE(memtoregE), .alusrcE(alusrcE), .branchE(branchE),
    .bneE(bneE), .jumpE(jumpE), .illegalE(illegalE)
  );

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [3:0]  alu;
    logic [7:0]  ctl;
    logic        illegal;
  } out_t;

  // ctl bit order: regwrite memread memwrite memtoreg alusrc branch bne jump
  // immk: 0 sign, 1 zero, 2 upper, 3 jump target
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] alu;
    logic [7:0] ctl;
    logic [1:0] immk;
  } row_t;

  row_t        tbl [17];
  out_t        sb_q [$];
  string       tag_q [$];
  logic [31:0] mregs [32];
  logic        mkill;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        drive_done = 1'b0;

  initial begin
    tbl[0]  = '{6'h00, 6'h20, 4'd0, 8'b1000_0000, 2'd0};
    tbl[1]  = '{6'h00, 6'h22, 4'd1, 8'b1000_0000, 2'd0};
    tbl[2]  = '{6'h00, 6'h24, 4'd2, 8'b1000_0000, 2'd0};
    tbl[3]  = '{6'h00, 6'h25, 4'd3, 8'b1000_0000, 2'd0};
    tbl[4]  = '{6'h00, 6'h2A, 4'd4, 8'b1000_0000, 2'd0};
    tbl[5]  = '{6'h00, 6'h00, 4'd5, 8'b1000_0000, 2'd0};
    tbl[6]  = '{6'h00, 6'h02, 4'd6, 8'b1000_0000, 2'd0};
    tbl[7]  = '{6'h08, 6'h00, 4'd0, 8'b1000_1000, 2'd0};
    tbl[8]  = '{6'h0C, 6'h00, 4'd2, 8'b1000_1000, 2'd1};
    tbl[9]  = '{6'h0D, 6'h00, 4'd3, 8'b1000_1000, 2'd1};
    tbl[10] = '{6'h0F, 6'h00, 4'd7, 8'b1000_1000, 2'd2};
    tbl[11] = '{6'h23, 6'h00, 4'd0, 8'b1101_1000, 2'd0};
    tbl[12] = '{6'h2B, 6'h00, 4'd0, 8'b0010_1000, 2'd0};
    tbl[13] = '{6'h04, 6'h00, 4'd1, 8'b0000_0100, 2'd0};
    tbl[14] = '{6'h05, 6'h00, 4'd1, 8'b0000_0110, 2'd0};
    tbl[15] = '{6'h02, 6'h00, 4'd0, 8'b0000_0001, 2'd3};
    tbl[16] = '{6'h3F, 6'h3F, 4'd0, 8'b0000_0000, 2'd0};
  end

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wd, input logic [31:0] wv);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && wd == a) return wv;
`endif
    return mregs[a];
  endfunction

  function automatic out_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] pcp4, input logic [31:0] r1,
                                        input logic [31:0] r2);
    out_t  e;
    int    hit = -1;
    logic [31:0] se;
    se = 32'($signed(ins[15:0]));
    for (int k = 0; k < 16; k++)
      if (tbl[k].op == ins[31:26] && (ins[31:26] != 6'h00 || tbl[k].fn == ins[5:0]) && hit < 0)
        hit = k;
    e = '0;
    e.rd1 = r1; e.rd2 = r2;
    e.rs = ins[25:21]; e.rt = ins[20:16]; e.shamt = ins[10:6];
    e.rd = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
    e.pc = pc; e.pcp4 = pcp4;
    e.imm = se;
    if (ins == 32'h0) begin
      e.alu = 4'd0; e.ctl = 8'h0;
    end else if (hit < 0) begin
      e.illegal = 1'b1;
    end else begin
      e.alu = tbl[hit].alu;
      e.ctl = tbl[hit].ctl;
      case (tbl[hit].immk)
        2'd1:    e.imm = {16'h0, ins[15:0]};
        2'd2:    e.imm = ins[15:0] * 32'h10000;
        2'd3:    e.imm = {pcp4[31:28], 28'h0} + {4'h0, ins[25:0], 2'b00};
        default: e.imm = se;
      endcase
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] pcp4, input logic br, input logic we,
                      input logic [4:0] wd, input logic [31:0] wv, input string tag);
    out_t e;
    @(negedge clk);
    rst = r; instrD = ins; pcD = pc; pcplus4D = pcp4;
    isbranchtakenE = br; regwriteW = we; rdW = wd; resultW = wv;
    if (r || br || mkill) e = '0;
    else e = model_decode(ins, pc, pcp4, model_read(ins[25:21], we, wd, wv),
                          model_read(ins[20:16], we, wd, wv));
    sb_q.push_back(e);
    tag_q.push_back(tag);
    if (r) begin
      for (int k = 0; k < 32; k++) mregs[k] = 32'h0;
      mkill = 1'b0;
    end else begin
      mkill = br;
      if (we && wd != 5'd0) mregs[wd] = wv;
    end
  endtask

  task automatic simple(input logic [31:0] ins, input string tag);
    step(1'b0, ins, 32'h0000_1000, 32'h0000_1004, 1'b0, 1'b0, 5'd0, 32'h0, tag);
  endtask

  task automatic wb(input logic [4:0] wd, input logic [31:0] wv);
    step(1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1, wd, wv, "wb_nop");
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [31:0] ins;
    logic [4:0]  a, b;
    k = $urandom_range(0, 18);
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    ins = $urandom;
    ins[25:21] = a; ins[20:16] = b;
    if (k <= 15) begin
      ins[31:26] = tbl[k].op;
      if (tbl[k].op == 6'h00) ins[5:0] = tbl[k].fn;
      if (tbl[k].op == 6'h02) ins[25:0] = 26'($urandom);
    end else if (k == 16) begin
      ins[31:26] = 6'h00; ins[5:0] = 6'h3F;
    end else if (k == 17) begin
      ins[31:26] = 6'h3F;
    end else begin
      ins = 32'h0;
    end
    return ins;
  endfunction

  // Monitor: every cycle the DUT presents a D->E register value, checked against the queue head
  always @(posedge clk) begin
    out_t  act, exp;
    string tag;
    #1;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      tag = tag_q.pop_front();
      act = {rd1E, rd2E, immE, rsE, rtE, rdE, shamtE, pcE, pcplus4E, aluopE,
             {regwriteE, memreadE, memwriteE, memtoregE, alusrcE, branchE, bneE, jumpE}, illegalE};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: actual %h required %h", tag, act, exp);
      end
    end
  end

  initial begin
    logic [31:0] ins, pc;
    mkill = 1'b0;
    for (int k = 0; k < 32; k++) mregs[k] = 32'h0;
    rst = 1'b1; instrD = 32'h0; pcD = 32'h0; pcplus4D = 32'h0;
    isbranchtakenE = 1'b0; regwriteW = 1'b0; rdW = 5'd0; resultW = 32'h0;

    step(1'b1, 32'h8C22_0004, 32'h100, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, "reset0");
    step(1'b1, 32'h8C22_0004, 32'h100, 32'h104, 1'b0, 1'b1, 5'd2, 32'h55, "reset1");
    for (int i = 1; i < 32; i++)
      simple({6'h00, 5'(i), 5'(i), 5'd3, 5'd0, 6'h20}, "post_reset_read");

    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    simple(32'h0022_1820, "add_3_1_2");
    simple(32'h2004_FFFF, "addi_sext");
    simple(32'h3404_FFFF, "ori_zext");
    simple(32'h3C04_1234, "lui");

    step(1'b0, 32'h8C22_0004, 32'h200, 32'h204, 1'b1, 1'b0, 5'd0, 32'h0, "squash_lw");
    step(1'b0, 32'hAC22_0008, 32'h204, 32'h208, 1'b0, 1'b0, 5'd0, 32'h0, "squash_sw");
    step(1'b0, 32'h0022_1820, 32'h208, 32'h20C, 1'b0, 1'b0, 5'd0, 32'h0, "after_squash");

    wb(5'd5, 32'd1);
    step(1'b0, 32'h00A0_3020, 32'h300, 32'h304, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, "same_cycle_rw");
    simple(32'h00A0_3020, "read_after_rw");

    simple(32'hFC00_0000, "illegal_op");
    simple(32'h0022_183F, "illegal_funct");
    step(1'b0, 32'h0800_0010, 32'h4000_0000, 32'h4000_0004, 1'b0, 1'b0, 5'd0, 32'h0, "jump");

    step(1'b0, 32'h0022_1820, 32'h400, 32'h404, 1'b1, 1'b0, 5'd0, 32'h0, "dbl_br0");
    step(1'b0, 32'h0022_1820, 32'h404, 32'h408, 1'b1, 1'b1, 5'd6, 32'h66, "dbl_br1_wb");
    step(1'b0, 32'h0022_1820, 32'h408, 32'h40C, 1'b0, 1'b0, 5'd0, 32'h0, "dbl_br_tail");
    simple(32'h00C6_3820, "wb_in_flush_committed");

    wb(5'd0, 32'hFFFF_FFFF);
    step(1'b0, 32'h0000_0020, 32'h500, 32'h504, 1'b0, 1'b1, 5'd0, 32'h1234, "read_r0");

    step(1'b0, 32'h0022_1820, 32'h600, 32'h604, 1'b1, 1'b0, 5'd0, 32'h0, "br_before_rst");
    step(1'b1, 32'h0022_1820, 32'h604, 32'h608, 1'b0, 1'b0, 5'd0, 32'h0, "mid_rst");
    simple(32'h0022_1820, "after_mid_rst");

    for (int i = 0; i < 1500; i++) begin
      ins = rand_instr();
      pc  = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(0, 99) == 0), ins, pc, pc + 32'd4,
           ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom, "random");
    end
    drive_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!drive_done && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (!drive_done || sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: actual pending=%0d done=%0d required pending=0 done=1", sb_q.size(), drive_done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
